// File: rtl/console_pkg.sv
// Shared constants and capture-FSM encoding for the console receive path.
package console_pkg;

   localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;
   localparam int          RX_VALID_BIT = 8;

   typedef enum logic {
      CAP_IDLE = 1'b0,
      CAP_HOLD = 1'b1
   } cap_state_e;

endpackage

// File: rtl/console_fifo_mem.sv
// Byte storage for the console receive FIFO: synchronous write, asynchronous read.
// The async read lets the core see the head byte in the same cycle, so this lives in LUT RAM.
module console_fifo_mem #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  CLK,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [7:0]            rdata
);

   logic [7:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/console_rx_fifo.sv
// Drains simpleuart received bytes into a small FIFO and offers the core a
// non-blocking read word (all zero when empty, valid bit + byte otherwise).
module console_rx_fifo
   import console_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [31:0]           uart_dat_do,
   output logic                  uart_dat_re,
   input  logic                  cpu_re,
   output logic [31:0]           cpu_rdata,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  clr_ovf,
   output cap_state_e            cap_state
);

   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

   // Handshakes: a byte is offered whenever uart_dat_do != UART_NO_DATA and is
   // taken only in IDLE; uart_dat_re is the one-cycle acknowledge, after which
   // HOLD skips the stale word. cpu_re is honoured only while count != 0.
   cap_state_e            state_q, state_d;
   logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  overflow_q, re_q, re_d;
   logic                  byte_avail, full, pop, push, drop;
   logic [7:0]            head_byte;

   assign byte_avail = (uart_dat_do != UART_NO_DATA);
   assign full       = (count_q == FULL_COUNT);
   assign pop        = cpu_re && (count_q != '0);

   always_comb begin
      state_d = state_q;
      re_d    = 1'b0;
      push    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         CAP_IDLE: begin
            if (byte_avail) begin
               re_d    = 1'b1;
               state_d = CAP_HOLD;
               // A coincident pop frees a slot, so a full FIFO still accepts.
               if (full && !pop) drop = 1'b1;
               else              push = 1'b1;
            end
         end
         CAP_HOLD: state_d = CAP_IDLE;
         default:  state_d = CAP_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= CAP_IDLE;
         re_q       <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         re_q    <= re_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
         if (drop)         overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   console_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .CLK   (CLK),
      .we    (push),
      .waddr (wptr_q),
      .wdata (uart_dat_do[7:0]),
      .raddr (rptr_q),
      .rdata (head_byte)
   );

   always_comb begin
      cpu_rdata = 32'h0;
      if (count_q != '0) begin
         cpu_rdata[7:0]          = head_byte;
         cpu_rdata[RX_VALID_BIT] = 1'b1;
      end
   end

   assign uart_dat_re = re_q;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign cap_state   = state_q;

endmodule

// File: tb/tb_console_rx_fifo.sv
// Bench for console_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_console_rx_fifo;
   import console_pkg::*;

   localparam logic [31:0] NO = 32'hFFFF_FFFF;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] uart_dat_do = NO;
   logic        uart_dat_re;
   logic        cpu_re = 1'b0;
   logic [31:0] cpu_rdata;
   logic [4:0]  count;
   logic        overflow;
   logic        clr_ovf = 1'b0;
   cap_state_e  cap_state;

   int n_pass  = 0;
   int n_total = 0;
   int re_pulses = 0;

   // clock/reset
   always #5 CLK = ~CLK;

   console_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .uart_dat_do (uart_dat_do),
      .uart_dat_re (uart_dat_re),
      .cpu_re      (cpu_re),
      .cpu_rdata   (cpu_rdata),
      .count       (count),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf),
      .cap_state   (cap_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // reference model: byte queue, sticky flag, and "acked last cycle" flag
   logic [7:0] exp_q[$];
   logic       m_ovf = 1'b0;
   logic       m_re  = 1'b0;
   logic       m_cap;

   always @(posedge CLK) begin
      if (RST) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_re  = 1'b0;
      end else begin
         m_cap = !m_re && (uart_dat_do != NO);
         if (cpu_re && exp_q.size() > 0) void'(exp_q.pop_front());
         if (clr_ovf) m_ovf = 1'b0;
         if (m_cap) begin
            if (exp_q.size() < 16) exp_q.push_back(uart_dat_do[7:0]);
            else m_ovf = 1'b1;
         end
         m_re = m_cap;
      end
   end

   // scoreboard compare, every cycle away from the active edge
   always @(negedge CLK) begin
      logic [31:0] exp_word;
      exp_word = (exp_q.size() == 0) ? 32'h0 : {23'b0, 1'b1, exp_q[0]};
      chk("model_count", {27'b0, count}, exp_q.size());
      chk("model_rdata", cpu_rdata, exp_word);
      chk("model_ovf", {31'b0, overflow}, {31'b0, m_ovf});
      chk("model_re", {31'b0, uart_dat_re}, {31'b0, m_re});
      if (uart_dat_re === 1'b1) re_pulses++;
   end

   // driver tasks
   task automatic step(input logic [31:0] dat, input logic re, input logic clr, input logic rst);
      uart_dat_do = dat;
      cpu_re      = re;
      clr_ovf     = clr;
      RST         = rst;
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      step({24'h0, b}, 1'b0, 1'b0, 1'b0);
      step(NO, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_byte();
      step(NO, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] dat;
      int pp, pr;

      step(NO, 1'b0, 1'b0, 1'b1);
      step(NO, 1'b0, 1'b0, 1'b1);
      step(NO, 1'b0, 1'b0, 1'b0);
      chk("reset_count", {27'b0, count}, 32'd0);
      chk("reset_rdata", cpu_rdata, 32'h0);
      chk("reset_ovf", {31'b0, overflow}, 32'd0);
      chk("reset_re", {31'b0, uart_dat_re}, 32'd0);

      // 1: single byte
      step(32'h41, 1'b0, 1'b0, 1'b0);
      chk("t1_re_pulse", {31'b0, uart_dat_re}, 32'd1);
      step(NO, 1'b0, 1'b0, 1'b0);
      chk("t1_re_low", {31'b0, uart_dat_re}, 32'd0);
      chk("t1_count", {27'b0, count}, 32'd1);
      chk("t1_rdata", cpu_rdata, 32'h141);

      // 2: three bytes, three pops
      push_byte(8'h42);
      push_byte(8'h43);
      chk("t2_read_a", cpu_rdata, 32'h141);
      pop_byte();
      chk("t2_read_b", cpu_rdata, 32'h142);
      pop_byte();
      chk("t2_read_c", cpu_rdata, 32'h143);
      pop_byte();
      chk("t2_empty", cpu_rdata, 32'h0);
      chk("t2_count", {27'b0, count}, 32'd0);

      // 3: 17 bytes into a 16-deep FIFO; last one also raises clr_ovf (set wins)
      re_pulses = 0;
      for (int i = 0; i < 17; i++) begin
         step({24'h0, 8'(i)}, 1'b0, (i == 16), 1'b0);
         step(NO, 1'b0, 1'b0, 1'b0);
      end
      chk("t3_count", {27'b0, count}, 32'd16);
      chk("t3_ovf", {31'b0, overflow}, 32'd1);
      chk("t3_pulses", re_pulses, 32'd17);
      for (int i = 0; i < 16; i++) begin
         chk("t3_pop", cpu_rdata, 32'h100 + i);
         pop_byte();
      end
      chk("t3_drained", cpu_rdata, 32'h0);
      step(NO, 1'b0, 1'b1, 1'b0);
      chk("t3_clr", {31'b0, overflow}, 32'd0);

      // 4: full FIFO, pop coincident with capture
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
      chk("t4_full", {27'b0, count}, 32'd16);
      chk("t4_head", cpu_rdata, 32'h120);
      step(32'h55, 1'b1, 1'b0, 1'b0);
      chk("t4_count", {27'b0, count}, 32'd16);
      chk("t4_ovf", {31'b0, overflow}, 32'd0);
      step(NO, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) pop_byte();
      chk("t4_last", cpu_rdata, 32'h155);
      pop_byte();
      chk("t4_empty", {27'b0, count}, 32'd0);

      // 5: pop while empty
      pop_byte();
      pop_byte();
      chk("t5_rdata", cpu_rdata, 32'h0);
      chk("t5_count", {27'b0, count}, 32'd0);
      push_byte(8'h5A);
      chk("t5_after", cpu_rdata, 32'h15A);
      pop_byte();

      // 6: reset while in HOLD with 5 bytes held
      for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
      step(32'h64, 1'b0, 1'b0, 1'b0);
      chk("t6_pre_count", {27'b0, count}, 32'd5);
      chk("t6_pre_re", {31'b0, uart_dat_re}, 32'd1);
      step(NO, 1'b0, 1'b0, 1'b1);
      chk("t6_count", {27'b0, count}, 32'd0);
      chk("t6_rdata", cpu_rdata, 32'h0);
      chk("t6_re", {31'b0, uart_dat_re}, 32'd0);
      chk("t6_ovf", {31'b0, overflow}, 32'd0);
      step(32'h99, 1'b0, 1'b0, 1'b0);
      chk("t6_resume_re", {31'b0, uart_dat_re}, 32'd1);
      step(NO, 1'b0, 1'b0, 1'b0);
      chk("t6_resume", cpu_rdata, 32'h199);
      pop_byte();

      // random push/pop: fill-heavy phase then drain-heavy phase
      for (int c = 0; c < 400; c++) begin
         pp = (c < 200) ? 80 : 40;
         pr = (c < 200) ? 30 : 70;
         if ($urandom_range(0, 99) < pp)
            dat = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom_range(0, 255))};
         else
            dat = NO;
         step(dat, ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < 5), 1'b0);
      end
      for (int i = 0; i < 20; i++) pop_byte();
      chk("final_count", {27'b0, count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
